// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit owning the HI/LO registers.
// Multiplies use one shift-add step per cycle, divides one restoring
// subtract-shift step per cycle, both on operand magnitudes. Signs are
// reapplied in a single FIX cycle before HI/LO are written.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  // Mult: {acc_hi, acc_lo} is the shifting product/multiplier pair.
  // Div:  acc_hi is the partial remainder, acc_lo the dividend/quotient.
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [WIDTH-1:0] operand_reg;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] raw_a_reg;     // unmodified dividend for divide-by-zero
  logic             is_div_reg;
  logic             neg_q_reg;     // negate product / quotient
  logic             neg_r_reg;     // negate remainder (dividend was negative)
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Operand sign extraction and magnitude conversion at issue time.
  always_comb begin
    is_signed = ~Op[0];
    a_neg     = is_signed & OperandA[WIDTH-1];
    b_neg     = is_signed & OperandB[WIDTH-1];
    a_mag     = a_neg ? -OperandA : OperandA;
    b_mag     = b_neg ? -OperandB : OperandB;
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // One iteration: shift-add for multiply, restoring subtract-shift for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, operand_reg} : '0);
    div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand_reg};
    if (is_div_reg) begin
      // A non-negative difference means the divisor fits: keep it, quotient bit 1.
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Final sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    prod_mag = {acc_hi_reg, acc_lo_reg};
    prod_res = neg_q_reg ? -prod_mag : prod_mag;
    if (!is_div_reg) begin
      fix_hi = prod_res[2*WIDTH-1:WIDTH];
      fix_lo = prod_res[WIDTH-1:0];
    end else if (operand_reg == '0) begin
      fix_hi = raw_a_reg;
      fix_lo = '1;
    end else begin
      fix_hi = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
      fix_lo = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
    end
  end

  // Control FSM, iteration datapath and HI/LO architectural state.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      operand_reg <= '0;
      raw_a_reg   <= '0;
      is_div_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            case (Op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                state_reg   <= RUN;
                busy_reg    <= 1'b1;
                count_reg   <= '0;
                is_div_reg  <= Op[1];
                neg_q_reg   <= a_neg ^ b_neg;
                neg_r_reg   <= a_neg;
                raw_a_reg   <= OperandA;
                acc_hi_reg  <= '0;
                acc_lo_reg  <= Op[1] ? a_mag : b_mag;
                operand_reg <= Op[1] ? b_mag : a_mag;
              end
              3'b100:  hi_reg <= OperandA;
              3'b101:  lo_reg <= OperandA;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc_hi_reg <= step_hi;
          acc_lo_reg <= step_lo;
          count_reg  <= count_reg + 1'b1;
          if (count_reg == LAST) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          hi_reg    <= fix_hi;
          lo_reg    <= fix_lo;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Busy = busy_reg;
  assign Done = done_reg;
  assign Hi   = hi_reg;
  assign Lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed testbench for muldiv_hilo with a result scoreboard.
module tb_muldiv_hilo;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  muldiv_hilo #(.WIDTH(32)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .Busy     (Busy),
    .Done     (Done),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_hi   = 32'h0;
  logic [31:0] exp_lo   = 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic returning {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_, q, r;
    logic [63:0]        ua, ub;
    sa = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'b000: return sa * sb_;
      3'b001: return ua * ub;
      3'b010: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issue one mult/div op, track Busy/Done, and compare against the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit intrude);
    int   busy_cycles;
    bit   seen_done;
    bit   stable;
    exp_t e;
    @(negedge Clock);
    sb.push_back({ehi, elo});
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(negedge Clock);
    Start = 1'b0;
    busy_cycles = 0;
    seen_done   = 1'b0;
    stable      = 1'b1;
    for (int i = 0; i < 60 && !seen_done; i++) begin
      if (Done) begin
        seen_done = 1'b1;
      end else begin
        if (Busy) busy_cycles++;
        if (Hi !== exp_hi || Lo !== exp_lo) stable = 1'b0;
        if (intrude && i == 5) begin
          Start = 1'b1; Op = 3'b000; OperandA = 32'h00000007; OperandB = 32'h00000009;
        end else begin
          Start = 1'b0;
        end
        @(negedge Clock);
      end
    end
    Start = 1'b0;
    e = sb.pop_front();
    check({tag, " done_seen"},   64'(seen_done),   64'd1);
    check({tag, " busy_cycles"}, 64'(busy_cycles), 64'd33);
    check({tag, " hilo_stable"}, 64'(stable),      64'd1);
    check({tag, " busy_at_done"}, 64'(Busy),       64'd0);
    check({tag, " hi"}, 64'(Hi), 64'(e.hi));
    check({tag, " lo"}, 64'(Lo), 64'(e.lo));
    exp_hi = e.hi;
    exp_lo = e.lo;
    @(negedge Clock);
    check({tag, " done_pulse"}, 64'(Done), 64'd0);
  endtask

  initial begin
    int          dones;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] m;

    // Reset held low with a request present: nothing may happen.
    Reset = 1'b0; Start = 1'b1; Op = 3'b100; OperandA = 32'h11111111; OperandB = 32'h0;
    @(negedge Clock);
    Op = 3'b000;
    @(negedge Clock);
    check("rst hi",   64'(Hi),   64'h0);
    check("rst lo",   64'(Lo),   64'h0);
    check("rst busy", 64'(Busy), 64'h0);
    check("rst done", 64'(Done), 64'h0);
    Start = 1'b0;
    Reset = 1'b1;

    run_op("mult",  3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_op("multu", 3'b001, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0);
    run_op("div",   3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu",  3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);
    run_op("divu0", 3'b011, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0);
    run_op("divovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("div0s", 3'b010, 32'h87654321, 32'h00000000, 32'h87654321, 32'hFFFFFFFF, 1'b0);

    // MTHI then MTLO back to back.
    @(negedge Clock);
    Start = 1'b1; Op = 3'b100; OperandA = 32'hDEADBEEF;
    @(negedge Clock);
    exp_hi = 32'hDEADBEEF;
    check("mthi hi",   64'(Hi),   64'(exp_hi));
    check("mthi lo",   64'(Lo),   64'(exp_lo));
    check("mthi done", 64'(Done), 64'h0);
    check("mthi busy", 64'(Busy), 64'h0);
    Op = 3'b101; OperandA = 32'hCAFEF00D;
    @(negedge Clock);
    exp_lo = 32'hCAFEF00D;
    Start = 1'b0;
    check("mtlo lo",   64'(Lo),   64'(exp_lo));
    check("mtlo hi",   64'(Hi),   64'(exp_hi));
    check("mtlo done", 64'(Done), 64'h0);

    // Reserved op is ignored.
    Start = 1'b1; Op = 3'b110; OperandA = 32'h55555555;
    @(negedge Clock);
    Start = 1'b0;
    check("rsv hi",   64'(Hi),   64'(exp_hi));
    check("rsv lo",   64'(Lo),   64'(exp_lo));
    check("rsv busy", 64'(Busy), 64'h0);
    @(negedge Clock);
    check("rsv done", 64'(Done), 64'h0);

    // Second Start mid-RUN must not disturb the first operation.
    run_op("intrude", 3'b000, 32'h00001234, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'hFFFEDCC0, 1'b1);

    // A few extra operations checked against the reference model.
    for (int k = 0; k < 4; k++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (k == 3) ? 32'h00000003 : $urandom;
      m   = model(rop, ra, rb);
      run_op($sformatf("rand%0d", k), rop, ra, rb, m[63:32], m[31:0], 1'b0);
    end

    // Reset asserted partway through a DIV aborts it cleanly.
    @(negedge Clock);
    Start = 1'b1; Op = 3'b010; OperandA = 32'h00000064; OperandB = 32'h00000007;
    @(negedge Clock);
    Start = 1'b0;
    repeat (10) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    check("abort busy", 64'(Busy), 64'h0);
    check("abort done", 64'(Done), 64'h0);
    check("abort hi",   64'(Hi),   64'h0);
    check("abort lo",   64'(Lo),   64'h0);
    Reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge Clock);
      if (Done) dones++;
    end
    check("abort no_done", 64'(dones), 64'h0);
    run_op("mult56", 3'b000, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
